// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch buffer entry, fetch FSM states and address helpers.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect and decode handoff.
interface instruction_fetch_unit_if;
  import cpu_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instruction;
  logic [XLEN-1:0] if_pc;

  modport master (
    output mem_req_valid, mem_req_addr, if_valid, if_instruction, if_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, if_valid, if_instruction, if_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch entries; head is presented combinationally.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// CPU fetch front end: owns the fetch PC, issues credit-limited word reads and buffers
// in-order responses for decode; redirects flush buffered and in-flight work.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                      clock,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_cnt_q;

  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_rdata;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  logic [CW:0]     in_use;
  logic            req_valid;
  logic            req_fire;
  logic            resp;
  logic            redir;
  logic [XLEN-1:0] redir_pc;
  logic [CW-1:0]   redir_drop;

  assign resp     = bus.mem_resp_valid;
  assign redir    = bus.redirect_valid;
  assign redir_pc = align_pc(bus.redirect_pc);

  // Every slot is either awaiting a response or holding one, so the buffer can never overflow.
  assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign req_valid = (state_q == RUN) && !redir && (in_use < (CW + 1)'(FIFO_DEPTH));
  assign req_fire  = req_valid && bus.mem_req_ready;

  assign redir_drop = outstanding_q - CW'(resp);

  assign fifo_push  = (state_q == RUN) && resp && !redir;
  assign fifo_pop   = !fifo_empty && bus.if_ready && !redir;
  assign fifo_wdata = '{instr: bus.mem_resp_data, pc: resp_pc_q};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (redir),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (fifo_push && !fifo_pop) begin
        assert (!fifo_full);
      end
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(resp);
      if (redir) begin
        // A response landing in the redirect cycle is stale and never counted as a drop.
        fetch_pc_q <= redir_pc;
        resp_pc_q  <= redir_pc;
        drop_cnt_q <= redir_drop;
        state_q    <= (redir_drop != '0) ? FLUSH : RUN;
      end else begin
        if (req_fire) begin
          fetch_pc_q <= fetch_pc_q + XLEN'(INSTR_BYTES);
        end
        case (state_q)
          IDLE: state_q <= RUN;
          RUN: begin
            if (resp) begin
              resp_pc_q <= resp_pc_q + XLEN'(INSTR_BYTES);
            end
          end
          FLUSH: begin
            if (resp) begin
              drop_cnt_q <= drop_cnt_q - CW'(1);
              if (drop_cnt_q == CW'(1)) begin
                state_q <= RUN;
              end
            end else if (drop_cnt_q == '0) begin
              state_q <= RUN;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_req_valid  = req_valid;
  assign bus.mem_req_addr   = fetch_pc_q;
  assign bus.if_valid       = !fifo_empty;
  assign bus.if_instruction = fifo_rdata.instr;
  assign bus.if_pc          = fifo_rdata.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with an in-order fixed-latency memory model.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;

  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  logic [31:0] req_log   [$];
  logic [31:0] pop_pc    [$];
  logic [31:0] pop_ins   [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Memory acceptance and decode-side consumption, seen at the active edge.
  always @(posedge clock) begin
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
      req_log.delete();
      pop_pc.delete();
      pop_ins.delete();
    end else begin
      cyc <= cyc + 1;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        pend_addr.push_back(bus.mem_req_addr);
        pend_due.push_back(cyc + lat);
        req_log.push_back(bus.mem_req_addr);
      end
      if (bus.if_valid && bus.if_ready && !bus.redirect_valid) begin
        pop_pc.push_back(bus.if_pc);
        pop_ins.push_back(bus.if_instruction);
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      bus.mem_resp_valid <= 1'b1;
      bus.mem_resp_data  <= mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      bus.mem_resp_valid <= 1'b0;
      bus.mem_resp_data  <= '0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    tick(2);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_req_addr", bus.mem_req_addr, 32'h0);
    chk("rst_if_instr", bus.if_instruction, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int mr;
    int mp;
    bus.mem_req_ready  = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b1;

    // 1: streaming with 1-cycle memory
    lat = 1;
    do_reset();
    tick(1);
    chk("t1_req_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("t1_addr0", bus.mem_req_addr, 32'h0);
    tick(1);
    chk("t1_addr4", bus.mem_req_addr, 32'h4);
    tick(1);
    chk("t1_if_valid", 32'(bus.if_valid), 32'd1);
    chk("t1_pc0", bus.if_pc, 32'h0);
    chk("t1_ins0", bus.if_instruction, mem_word(32'h0));
    tick(1);
    chk("t1_pc4", bus.if_pc, 32'h4);
    tick(1);
    chk("t1_pc8", bus.if_pc, 32'h8);
    chk("t1_ins8", bus.if_instruction, mem_word(32'h8));
    chk("t1_req_n", 32'(req_log.size() >= 3), 32'd1);
    chk("t1_req2", req_log[2], 32'h8);

    // 2: decode stalled, credits exhausted, then drain
    bus.if_ready = 1'b0;
    do_reset();
    tick(11);
    chk("t2_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("t2_req_cnt", 32'(req_log.size()), 32'(DEPTH));
    chk("t2_head_pc", bus.if_pc, 32'h0);
    bus.if_ready = 1'b1;
    tick(12);
    chk("t2_pop_n", 32'(pop_pc.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("t2_pop_pc", pop_pc[i], 32'(4 * i));
      chk("t2_pop_ins", pop_ins[i], mem_word(32'(4 * i)));
    end

    // 3: memory back-pressure holds the request
    bus.mem_req_ready = 1'b0;
    do_reset();
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("t3_hold_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("t3_hold_addr", bus.mem_req_addr, 32'h0);
    end
    chk("t3_no_issue", 32'(req_log.size()), 32'd0);
    bus.mem_req_ready = 1'b1;
    tick(1);
    chk("t3_one_issue", 32'(req_log.size()), 32'd1);
    chk("t3_issue_addr", req_log[0], 32'h0);
    chk("t3_next_addr", bus.mem_req_addr, 32'h4);

    // 4: redirect with two requests in flight on a 3-cycle memory
    lat = 3;
    do_reset();
    tick(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0104;
    tick(1);
    chk("t4_flush", 32'(dut.state_q), 32'(FLUSH));
    chk("t4_no_issue", 32'(req_log.size()), 32'd2);
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_req_blocked", 32'(bus.mem_req_valid), 32'd0);
    chk("t4_if_valid", 32'(bus.if_valid), 32'd0);
    tick(1);
    chk("t4_still_flush", 32'(dut.state_q), 32'(FLUSH));
    tick(1);
    chk("t4_run", 32'(dut.state_q), 32'(RUN));
    chk("t4_addr", bus.mem_req_addr, 32'h104);
    tick(8);
    chk("t4_pop_n", 32'(pop_pc.size() >= 2), 32'd1);
    chk("t4_pc104", pop_pc[0], 32'h104);
    chk("t4_pc108", pop_pc[1], 32'h108);
    chk("t4_ins104", pop_ins[0], mem_word(32'h104));

    // 5: redirect coinciding with a response and a decode pop
    lat = 1;
    do_reset();
    tick(5);
    chk("t5_pre_valid", 32'(bus.if_valid), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    tick(1);
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_if_valid", 32'(bus.if_valid), 32'd0);
    chk("t5_run", 32'(dut.state_q), 32'(RUN));
    chk("t5_pop_cnt", 32'(pop_pc.size()), 32'd2);
    chk("t5_addr", bus.mem_req_addr, 32'h40);
    tick(6);
    chk("t5_pop_n", 32'(pop_pc.size() >= 3), 32'd1);
    chk("t5_pc40", pop_pc[2], 32'h40);

    // 6: address wrap and low-bit masking on redirect
    do_reset();
    tick(3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick(1);
    bus.redirect_valid = 1'b0;
    mr = req_log.size();
    mp = pop_pc.size();
    tick(8);
    chk("t6_req_n", 32'(req_log.size() >= mr + 3), 32'd1);
    chk("t6_req_top", req_log[mr], 32'hFFFF_FFFC);
    chk("t6_req_wrap", req_log[mr + 1], 32'h0);
    chk("t6_req_4", req_log[mr + 2], 32'h4);
    chk("t6_pop_n", 32'(pop_pc.size() >= mp + 2), 32'd1);
    chk("t6_pop_top", pop_pc[mp], 32'hFFFF_FFFC);
    chk("t6_ins_top", pop_ins[mp], mem_word(32'hFFFF_FFFC));
    chk("t6_pop_wrap", pop_pc[mp + 1], 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0023;
    tick(1);
    bus.redirect_valid = 1'b0;
    mr = req_log.size();
    mp = pop_pc.size();
    tick(6);
    chk("t6_align_n", 32'(req_log.size() > mr && pop_pc.size() > mp), 32'd1);
    chk("t6_align_req", req_log[mr], 32'h20);
    chk("t6_align_pop", pop_pc[mp], 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
